alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/spu_pkg.sv | 45 ++++
 rtl/alu_operand_mux.sv | 51 +++++
 rtl/alu_issue.sv | 130 +++++++++++++
 tb/tb_alu_issue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared SPU definitions: op encodings, instruction field positions,
// per-op execute latency and the issue FSM state type.
package spu_pkg;

    localparam logic [5:0] OP_ILH  = 6'd0;
    localparam logic [5:0] OP_ILW  = 6'd2;
    localparam logic [5:0] OP_AH   = 6'd4;
    localparam logic [5:0] OP_AHI  = 6'd6;
    localparam logic [5:0] OP_SFH  = 6'd12;
    localparam logic [5:0] OP_MPYH = 6'd20;
    localparam logic [5:0] OP_RR28 = 6'd28;
    localparam logic [5:0] OP_RR30 = 6'd30;
    localparam logic [5:0] OP_IDLE = 6'd63;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RT_MSB    = 25;
    localparam int RT_LSB    = 19;
    localparam int RA_MSB    = 18;
    localparam int RA_LSB    = 12;
    localparam int RB_MSB    = 11;
    localparam int RB_LSB    = 5;
    localparam int IMM16_MSB = 15;
    localparam int IMM10_MSB = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } issue_state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ILH, OP_ILW, OP_AH, OP_AHI,
            OP_SFH, OP_MPYH, OP_RR28, OP_RR30: is_legal_op = 1'b1;
            default:                           is_legal_op = 1'b0;
        endcase
    endfunction

    // Execute cycles per op; MPYH is the only multi-cycle operation.
    function automatic logic [1:0] exec_latency(input logic [5:0] op);
        exec_latency = (op == OP_MPYH) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// Combinational operand selection: maps op, immediates and register read
// data onto the ALU A/B operand buses.
module alu_operand_mux
    import spu_pkg::*;
#(
    parameter int dataWidth = 128
) (
    input  logic [5:0]           op,
    input  logic [15:0]          imm16,
    input  logic [dataWidth-1:0] ra_data,
    input  logic [dataWidth-1:0] rb_data,
    output logic [dataWidth-1:0] in_a,
    output logic [dataWidth-1:0] in_b
);

    localparam int wordWidth  = dataWidth / 4;
    localparam int hwordWidth = dataWidth / 8;

    logic [31:0] imm16_sext;
    logic [15:0] imm10_sext;

    assign imm16_sext = {{16{imm16[15]}}, imm16};
    assign imm10_sext = {{6{imm16[IMM10_MSB]}}, imm16[IMM10_MSB:0]};

    // SFH swaps the register operands so the ALU's B - A yields ra - rb.
    always_comb begin
        in_a = '0;
        in_b = '0;
        case (op)
            OP_ILH: in_b[hwordWidth-1:0] = hwordWidth'(imm16);
            OP_ILW: in_b[wordWidth-1:0]  = wordWidth'(imm16_sext);
            OP_AHI: begin
                in_a                 = ra_data;
                in_b[hwordWidth-1:0] = hwordWidth'(imm10_sext);
            end
            OP_SFH: begin
                in_a = rb_data;
                in_b = ra_data;
            end
            OP_AH, OP_MPYH, OP_RR28, OP_RR30: begin
                in_a = ra_data;
                in_b = rb_data;
            end
            default: begin
                in_a = '0;
                in_b = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Single-issue ALU sequencer: accepts one instruction, drives the ALU for
// its execute latency, then writes the result back to the register file.
module alu_issue
    import spu_pkg::*;
#(
    parameter int dataWidth = 128
) (
    input  logic                 clk_fake,
    input  logic                 rst_n,
    input  logic                 instrValid,
    output logic                 instrReady,
    input  logic [31:0]          instr,
    output logic [6:0]           rfRdAddrA,
    output logic [6:0]           rfRdAddrB,
    input  logic [dataWidth-1:0] rfRdDataA,
    input  logic [dataWidth-1:0] rfRdDataB,
    output logic [5:0]           opCode,
    output logic [dataWidth-1:0] inA,
    output logic [dataWidth-1:0] inB,
    input  logic [dataWidth-1:0] aluDataOut,
    output logic                 rfWrEn,
    output logic [6:0]           rfWrAddr,
    output logic [dataWidth-1:0] rfWrData,
    output logic                 busy,
    output logic                 illegalOp
);

    issue_state_t         state;
    issue_state_t         next_state;
    logic                 ready_q;
    logic                 illegal_q;
    logic                 accept;
    logic                 instr_legal;
    logic                 exec_done;
    logic [5:0]           instr_op;
    logic [5:0]           op_q;
    logic [6:0]           rt_q;
    logic [1:0]           cnt_q;
    logic [dataWidth-1:0] mux_a;
    logic [dataWidth-1:0] mux_b;
    logic [dataWidth-1:0] in_a_q;
    logic [dataWidth-1:0] in_b_q;
    logic [dataWidth-1:0] wr_data_q;

    assign instr_op    = instr[OP_MSB:OP_LSB];
    assign rfRdAddrA   = instr[RA_MSB:RA_LSB];
    assign rfRdAddrB   = instr[RB_MSB:RB_LSB];
    assign instr_legal = is_legal_op(instr_op);
    assign accept      = instrValid && instrReady;
    assign exec_done   = (state == ST_EXEC) && (cnt_q == 2'd0);

    alu_operand_mux #(
        .dataWidth(dataWidth)
    ) u_operand_mux (
        .op     (instr_op),
        .imm16  (instr[IMM16_MSB:0]),
        .ra_data(rfRdDataA),
        .rb_data(rfRdDataB),
        .in_a   (mux_a),
        .in_b   (mux_b)
    );

    // ready_q keeps instrReady low until the first edge after reset release.
    always_ff @(posedge clk_fake or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept && instr_legal) next_state = ST_EXEC;
            ST_EXEC: if (cnt_q == 2'd0) next_state = ST_WB;
            ST_WB:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_fake or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_IDLE;
            rt_q      <= '0;
            cnt_q     <= '0;
            in_a_q    <= '0;
            in_b_q    <= '0;
            wr_data_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept && instr_legal) begin
                op_q   <= instr_op;
                rt_q   <= instr[RT_MSB:RT_LSB];
                in_a_q <= mux_a;
                in_b_q <= mux_b;
                cnt_q  <= exec_latency(instr_op) - 2'd1;
            end else if ((state == ST_EXEC) && (cnt_q != 2'd0)) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (accept && !instr_legal) begin
                illegal_q <= 1'b1;
            end
            if (exec_done) begin
                wr_data_q <= aluDataOut;
            end
        end
    end

    always_comb begin
        instrReady = (state == ST_IDLE) && ready_q;
        busy       = (state != ST_IDLE);
        rfWrEn     = (state == ST_WB);
        opCode     = OP_IDLE;
        inA        = '0;
        inB        = '0;
        if (state == ST_EXEC) begin
            opCode = op_q;
            inA    = in_a_q;
            inB    = in_b_q;
        end
    end

    assign rfWrAddr  = rt_q;
    assign rfWrData  = wr_data_q;
    assign illegalOp = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural register file and ALU
// around the DUT, with a lane-level reference model for expected results.
module tb_alu_issue;

    localparam int DW = 128;

    localparam logic [5:0] T_ILH  = 6'd0;
    localparam logic [5:0] T_ILW  = 6'd2;
    localparam logic [5:0] T_AH   = 6'd4;
    localparam logic [5:0] T_AHI  = 6'd6;
    localparam logic [5:0] T_SFH  = 6'd12;
    localparam logic [5:0] T_MPYH = 6'd20;

    logic          clk_fake = 1'b0;
    logic          rst_n = 1'b1;
    logic          instrValid = 1'b0;
    logic          instrReady;
    logic [31:0]   instr = '0;
    logic [6:0]    rfRdAddrA, rfRdAddrB;
    logic [DW-1:0] rfRdDataA, rfRdDataB;
    logic [5:0]    opCode;
    logic [DW-1:0] inA, inB;
    logic [DW-1:0] aluDataOut = '0;
    logic          rfWrEn;
    logic [6:0]    rfWrAddr;
    logic [DW-1:0] rfWrData;
    logic          busy;
    logic          illegalOp;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rf [0:127];
    logic          load_en = 1'b0;
    logic [6:0]    load_addr = '0;
    logic [DW-1:0] load_data = '0;

    int            wb_cycle, wb_count, exec_cnt, idle_cycle;
    logic [6:0]    wb_addr;
    logic [DW-1:0] wb_data, first_a, first_b;
    logic [5:0]    op_seen;
    logic          stable;

    alu_issue #(.dataWidth(DW)) dut (
        .clk_fake  (clk_fake),
        .rst_n     (rst_n),
        .instrValid(instrValid),
        .instrReady(instrReady),
        .instr     (instr),
        .rfRdAddrA (rfRdAddrA),
        .rfRdAddrB (rfRdAddrB),
        .rfRdDataA (rfRdDataA),
        .rfRdDataB (rfRdDataB),
        .opCode    (opCode),
        .inA       (inA),
        .inB       (inB),
        .aluDataOut(aluDataOut),
        .rfWrEn    (rfWrEn),
        .rfWrAddr  (rfWrAddr),
        .rfWrData  (rfWrData),
        .busy      (busy),
        .illegalOp (illegalOp)
    );

    always #5 clk_fake = ~clk_fake;

    assign rfRdDataA = rf[rfRdAddrA];
    assign rfRdDataB = rf[rfRdAddrB];

    always @(posedge clk_fake) begin
        if (load_en) rf[load_addr] <= load_data;
        else if (rfWrEn) rf[rfWrAddr] <= rfWrData;
    end

    // ALU stand-in: computes from the operand buses, updating on negedge.
    function automatic logic [DW-1:0] alu_stub(input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int w = 0; w < 4; w++) begin
            case (op)
                6'd0:  r[w*32 +: 32] = {16'h0, b[15:0]};
                6'd2:  r[w*32 +: 32] = b[31:0];
                6'd20: r[w*32 +: 32] = 32'(a[w*32 +: 16]) * 32'(b[w*32 +: 16]);
                6'd28: r[w*32 +: 32] = a[w*32 +: 32] & b[w*32 +: 32];
                6'd30: r[w*32 +: 32] = a[w*32 +: 32] | b[w*32 +: 32];
                default: ;
            endcase
        end
        for (int h = 0; h < 8; h++) begin
            case (op)
                6'd4:  r[h*16 +: 16] = a[h*16 +: 16] + b[h*16 +: 16];
                6'd6:  r[h*16 +: 16] = a[h*16 +: 16] + b[15:0];
                6'd12: r[h*16 +: 16] = b[h*16 +: 16] - a[h*16 +: 16];
                default: ;
            endcase
        end
        return r;
    endfunction

    always @(negedge clk_fake) aluDataOut <= alu_stub(opCode, inA, inB);

    // Architectural result of an instruction from its register values.
    function automatic logic [DW-1:0] ref_result(input logic [31:0] ins, input logic [DW-1:0] ra_v, input logic [DW-1:0] rb_v);
        logic [DW-1:0] r;
        logic [15:0]   imm16;
        logic [15:0]   s10;
        imm16 = ins[15:0];
        s10   = {{6{ins[9]}}, ins[9:0]};
        r     = '0;
        for (int w = 0; w < 4; w++) begin
            case (ins[31:26])
                6'd0:  r[w*32 +: 32] = {16'h0, imm16};
                6'd2:  r[w*32 +: 32] = {{16{imm16[15]}}, imm16};
                6'd20: r[w*32 +: 32] = 32'(ra_v[w*32 +: 16]) * 32'(rb_v[w*32 +: 16]);
                6'd28: r[w*32 +: 32] = ra_v[w*32 +: 32] & rb_v[w*32 +: 32];
                6'd30: r[w*32 +: 32] = ra_v[w*32 +: 32] | rb_v[w*32 +: 32];
                default: ;
            endcase
        end
        for (int h = 0; h < 8; h++) begin
            case (ins[31:26])
                6'd4:  r[h*16 +: 16] = ra_v[h*16 +: 16] + rb_v[h*16 +: 16];
                6'd6:  r[h*16 +: 16] = ra_v[h*16 +: 16] + s10;
                6'd12: r[h*16 +: 16] = ra_v[h*16 +: 16] - rb_v[h*16 +: 16];
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic ref_operands(input logic [31:0] ins, input logic [DW-1:0] ra_v, input logic [DW-1:0] rb_v,
                                output logic [DW-1:0] a, output logic [DW-1:0] b);
        a = '0;
        b = '0;
        case (ins[31:26])
            6'd0:  b[15:0] = ins[15:0];
            6'd2:  b[31:0] = {{16{ins[15]}}, ins[15:0]};
            6'd6:  begin a = ra_v; b[15:0] = {{6{ins[9]}}, ins[9:0]}; end
            6'd12: begin a = rb_v; b = ra_v; end
            default: begin a = ra_v; b = rb_v; end
        endcase
    endtask

    function automatic logic [31:0] mk_rr(input logic [5:0] op, input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb);
        return {op, rt, ra, rb, 5'b0};
    endfunction

    function automatic logic [31:0] mk_i16(input logic [5:0] op, input logic [6:0] rt, input logic [15:0] imm);
        return {op, rt, 3'b0, imm};
    endfunction

    function automatic logic [31:0] mk_i10(input logic [5:0] op, input logic [6:0] rt, input logic [6:0] ra, input logic [9:0] imm);
        return {op, rt, ra, 2'b0, imm};
    endfunction

    task automatic step();
        @(posedge clk_fake);
        #1;
    endtask

    task automatic load_reg(input logic [6:0] addr, input logic [DW-1:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        step();
        load_en = 1'b0;
    endtask

    // Issues one instruction and records what happens, cycle 1 being the accept cycle.
    task automatic run_instr(input logic [31:0] ins);
        logic [5:0] first_op;
        wb_cycle = -1; wb_count = 0; exec_cnt = 0; idle_cycle = -1;
        wb_addr = '0; wb_data = '0; first_a = '0; first_b = '0;
        op_seen = 6'd63; first_op = 6'd63; stable = 1'b1;
        instr = ins;
        instrValid = 1'b1;
        step();
        instrValid = 1'b0;
        instr = $urandom;
        for (int c = 2; c <= 12; c++) begin
            if (opCode != 6'd63) begin
                if (exec_cnt == 0) begin
                    first_op = opCode; first_a = inA; first_b = inB;
                end else if (opCode !== first_op || inA !== first_a || inB !== first_b) begin
                    stable = 1'b0;
                end
                exec_cnt++;
                op_seen = opCode;
            end
            if (rfWrEn) begin
                wb_count++;
                if (wb_cycle < 0) begin
                    wb_cycle = c; wb_addr = rfWrAddr; wb_data = rfWrData;
                end
            end
            if (instrReady) begin
                idle_cycle = c;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (instrReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", instrReady); end
        checks++; if (busy !== 1'b0 || rfWrEn !== 1'b0 || illegalOp !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got busy=%b wrEn=%b illegal=%b want 0", busy, rfWrEn, illegalOp); end
        checks++; if (opCode !== 6'd63) begin errors++; $display("[TB] FAIL reset_opcode: got %0d want 63", opCode); end
        checks++; if (inA !== '0 || inB !== '0 || rfWrData !== '0 || rfWrAddr !== 7'd0) begin errors++; $display("[TB] FAIL reset_buses: got inA=%h inB=%h wrData=%h wrAddr=%0d want 0", inA, inB, rfWrData, rfWrAddr); end
        step();
        step();
        @(negedge clk_fake);
        rst_n = 1'b1;
        #1;
        checks++; if (instrReady !== 1'b0) begin errors++; $display("[TB] FAIL ready_before_edge: got %b want 0", instrReady); end
        step();
        checks++; if (instrReady !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_release: got %b want 1", instrReady); end
    endtask

    task automatic test_ilh();
        run_instr(mk_i16(T_ILH, 7'd5, 16'h1234));
        checks++; if (wb_cycle !== 3) begin errors++; $display("[TB] FAIL ilh_wb_cycle: got %0d want 3", wb_cycle); end
        checks++; if (wb_count !== 1) begin errors++; $display("[TB] FAIL ilh_wb_count: got %0d want 1", wb_count); end
        checks++; if (wb_addr !== 7'd5) begin errors++; $display("[TB] FAIL ilh_wb_addr: got %0d want 5", wb_addr); end
        checks++; if (wb_data !== {4{32'h0000_1234}}) begin errors++; $display("[TB] FAIL ilh_data: got %h want %h", wb_data, {4{32'h0000_1234}}); end
        checks++; if (idle_cycle !== 4) begin errors++; $display("[TB] FAIL ilh_idle_cycle: got %0d want 4", idle_cycle); end
    endtask

    task automatic test_ah();
        load_reg(7'd1, {4{32'h0001_0002}});
        load_reg(7'd2, {8{16'hFFFF}});
        run_instr(mk_rr(T_AH, 7'd6, 7'd1, 7'd2));
        checks++; if (wb_data !== {4{32'h0000_0001}}) begin errors++; $display("[TB] FAIL ah_data: got %h want %h", wb_data, {4{32'h0000_0001}}); end
        checks++; if (wb_cycle !== 3 || wb_addr !== 7'd6) begin errors++; $display("[TB] FAIL ah_wb: got cycle=%0d addr=%0d want cycle=3 addr=6", wb_cycle, wb_addr); end
    endtask

    task automatic test_mpyh();
        load_reg(7'd3, {4{32'd3}});
        load_reg(7'd4, {4{32'd4}});
        run_instr(mk_rr(T_MPYH, 7'd7, 7'd3, 7'd4));
        checks++; if (wb_data !== {4{32'd12}}) begin errors++; $display("[TB] FAIL mpyh_data: got %h want %h", wb_data, {4{32'd12}}); end
        checks++; if (wb_cycle !== 4 || wb_count !== 1) begin errors++; $display("[TB] FAIL mpyh_wb: got cycle=%0d count=%0d want cycle=4 count=1", wb_cycle, wb_count); end
        checks++; if (exec_cnt !== 2 || op_seen !== T_MPYH || stable !== 1'b1) begin errors++; $display("[TB] FAIL mpyh_exec: got cycles=%0d op=%0d stable=%b want 2/20/1", exec_cnt, op_seen, stable); end
        checks++; if (idle_cycle !== 5) begin errors++; $display("[TB] FAIL mpyh_idle_cycle: got %0d want 5", idle_cycle); end
    endtask

    task automatic test_sfh_ahi();
        load_reg(7'd8, {8{16'd5}});
        load_reg(7'd9, {8{16'd7}});
        run_instr(mk_rr(T_SFH, 7'd12, 7'd8, 7'd9));
        checks++; if (wb_data !== {8{16'hFFFE}}) begin errors++; $display("[TB] FAIL sfh_data: got %h want %h", wb_data, {8{16'hFFFE}}); end
        checks++; if (first_a !== {8{16'd7}} || first_b !== {8{16'd5}}) begin errors++; $display("[TB] FAIL sfh_operands: got inA=%h inB=%h want rb on A, ra on B", first_a, first_b); end
        run_instr(mk_i10(T_AHI, 7'd13, 7'd8, 10'h3FF));
        checks++; if (wb_data !== {8{16'd4}}) begin errors++; $display("[TB] FAIL ahi_data: got %h want %h", wb_data, {8{16'd4}}); end
        checks++; if (wb_cycle !== 3 || wb_addr !== 7'd13) begin errors++; $display("[TB] FAIL ahi_wb: got cycle=%0d addr=%0d want 3/13", wb_cycle, wb_addr); end
    endtask

    task automatic test_illegal();
        int extra_wr;
        extra_wr = 0;
        run_instr(mk_rr(6'd9, 7'd20, 7'd1, 7'd2));
        checks++; if (illegalOp !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %b want 1", illegalOp); end
        checks++; if (idle_cycle !== 2 || exec_cnt !== 0 || wb_count !== 0) begin errors++; $display("[TB] FAIL illegal_flow: got idle=%0d exec=%0d wb=%0d want 2/0/0", idle_cycle, exec_cnt, wb_count); end
        for (int c = 0; c < 3; c++) begin
            if (rfWrEn || busy) extra_wr++;
            step();
        end
        checks++; if (extra_wr !== 0) begin errors++; $display("[TB] FAIL illegal_quiet: got %0d active cycles want 0", extra_wr); end
        run_instr(mk_i16(T_ILW, 7'd21, 16'h8001));
        checks++; if (wb_data !== {4{32'hFFFF_8001}} || wb_cycle !== 3) begin errors++; $display("[TB] FAIL ilw_after_illegal: got %h cycle=%0d want %h cycle=3", wb_data, wb_cycle, {4{32'hFFFF_8001}}); end
        checks++; if (illegalOp !== 1'b1) begin errors++; $display("[TB] FAIL illegal_sticky: got %b want 1", illegalOp); end
    endtask

    task automatic test_back_to_back();
        int            cyc_q[$];
        logic [DW-1:0] val_q[$];
        logic [6:0]    adr_q[$];
        int            busy_ok;
        busy_ok = 0;
        instr = mk_i16(T_ILH, 7'd10, 16'h0007);
        instrValid = 1'b1;
        step();
        instr = mk_rr(T_AH, 7'd11, 7'd10, 7'd10);
        for (int c = 2; c <= 10; c++) begin
            if (rfWrEn) begin
                cyc_q.push_back(c); val_q.push_back(rfWrData); adr_q.push_back(rfWrAddr);
            end
            if ((c == 2 || c == 3) && !instrReady) busy_ok++;
            if (c == 5) instrValid = 1'b0;
            step();
        end
        instrValid = 1'b0;
        checks++; if (busy_ok !== 2) begin errors++; $display("[TB] FAIL b2b_not_ready: got %0d want 2", busy_ok); end
        checks++; if (cyc_q.size() !== 2) begin errors++; $display("[TB] FAIL b2b_wb_count: got %0d want 2", cyc_q.size()); end
        if (cyc_q.size() == 2) begin
            checks++; if (cyc_q[0] !== 3 || cyc_q[1] !== 6) begin errors++; $display("[TB] FAIL b2b_wb_cycles: got %0d,%0d want 3,6", cyc_q[0], cyc_q[1]); end
            checks++; if (adr_q[0] !== 7'd10 || adr_q[1] !== 7'd11) begin errors++; $display("[TB] FAIL b2b_wb_addr: got %0d,%0d want 10,11", adr_q[0], adr_q[1]); end
            checks++; if (val_q[1] !== {4{32'h0000_000E}}) begin errors++; $display("[TB] FAIL b2b_dependent: got %h want %h", val_q[1], {4{32'h0000_000E}}); end
        end
    endtask

    task automatic test_random();
        logic [5:0]    ops [8];
        logic [31:0]   ins;
        logic [DW-1:0] ra_v, rb_v, exp_v, exp_a, exp_b;
        int            lat;
        ops = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd12, 6'd20, 6'd28, 6'd30};
        for (int n = 0; n < 30; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 7)];
            load_reg(ins[18:12], {$urandom, $urandom, $urandom, $urandom});
            load_reg(ins[11:5], {$urandom, $urandom, $urandom, $urandom});
            ra_v  = rf[ins[18:12]];
            rb_v  = rf[ins[11:5]];
            exp_v = ref_result(ins, ra_v, rb_v);
            ref_operands(ins, ra_v, rb_v, exp_a, exp_b);
            lat   = (ins[31:26] == T_MPYH) ? 2 : 1;
            instr = ins;
            #1;
            checks++; if (rfRdAddrA !== ins[18:12] || rfRdAddrB !== ins[11:5]) begin errors++; $display("[TB] FAIL rnd_rd_addr: got %0d,%0d want %0d,%0d", rfRdAddrA, rfRdAddrB, ins[18:12], ins[11:5]); end
            run_instr(ins);
            checks++; if (wb_data !== exp_v) begin errors++; $display("[TB] FAIL rnd_data op=%0d: got %h want %h", ins[31:26], wb_data, exp_v); end
            checks++; if (wb_addr !== ins[25:19] || wb_count !== 1) begin errors++; $display("[TB] FAIL rnd_wb op=%0d: got addr=%0d count=%0d want %0d/1", ins[31:26], wb_addr, wb_count, ins[25:19]); end
            checks++; if (wb_cycle !== lat + 2 || idle_cycle !== lat + 3 || exec_cnt !== lat) begin errors++; $display("[TB] FAIL rnd_timing op=%0d: got wb=%0d idle=%0d exec=%0d want %0d/%0d/%0d", ins[31:26], wb_cycle, idle_cycle, exec_cnt, lat + 2, lat + 3, lat); end
            checks++; if (op_seen !== ins[31:26] || stable !== 1'b1) begin errors++; $display("[TB] FAIL rnd_opcode: got %0d stable=%b want %0d stable=1", op_seen, stable, ins[31:26]); end
            checks++; if (first_a !== exp_a || first_b !== exp_b) begin errors++; $display("[TB] FAIL rnd_operands op=%0d: got inA=%h inB=%h want %h %h", ins[31:26], first_a, first_b, exp_a, exp_b); end
        end
    endtask

    task automatic test_reset_mid_exec();
        int wr_seen;
        wr_seen = 0;
        load_reg(7'd3, {4{32'd3}});
        load_reg(7'd4, {4{32'd4}});
        load_reg(7'd30, {4{32'hA5A5_5A5A}});
        instr = mk_rr(T_MPYH, 7'd30, 7'd3, 7'd4);
        instrValid = 1'b1;
        step();
        instrValid = 1'b0;
        checks++; if (opCode !== T_MPYH) begin errors++; $display("[TB] FAIL mid_exec_opcode: got %0d want 20", opCode); end
        rst_n = 1'b0;
        #1;
        checks++; if (opCode !== 6'd63 || busy !== 1'b0 || rfWrEn !== 1'b0) begin errors++; $display("[TB] FAIL mid_exec_abort: got op=%0d busy=%b wrEn=%b want 63/0/0", opCode, busy, rfWrEn); end
        checks++; if (illegalOp !== 1'b0 || instrReady !== 1'b0) begin errors++; $display("[TB] FAIL mid_exec_flags: got illegal=%b ready=%b want 0/0", illegalOp, instrReady); end
        for (int c = 0; c < 2; c++) begin
            if (rfWrEn) wr_seen++;
            step();
        end
        @(negedge clk_fake);
        rst_n = 1'b1;
        step();
        checks++; if (instrReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_exec_ready: got %b want 1", instrReady); end
        for (int c = 0; c < 4; c++) begin
            if (rfWrEn) wr_seen++;
            step();
        end
        checks++; if (wr_seen !== 0 || rf[30] !== {4{32'hA5A5_5A5A}}) begin errors++; $display("[TB] FAIL mid_exec_no_wb: got %0d writes r30=%h want 0 writes", wr_seen, rf[30]); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_ilh();
        test_ah();
        test_mpyh();
        test_sfh_ahi();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
